// File: rtl/rhx_session_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rhx_session_sequencer
// Description : AXI4-Lite master that runs one hardware-timed session:
//               configure RHD, enable RHS stim, verify the enable by
//               readback, wait a lead time, enable RHD acquisition, run, and
//               then disable RHS and RHD in that order.
// Revision    : 1.0 - initial release
// ============================================================================
module rhx_session_sequencer #(
    parameter logic [31:0] RHD_BASE = 32'h0000_0000,
    parameter logic [31:0] RHS_BASE = 32'h0001_0000,
    parameter int          LEAD_W   = 24,
    parameter int          RUN_W    = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       rhd_delay,
    input  logic [31:0]       rhd_pktlen,
    input  logic [31:0]       rhd_ctrl,
    input  logic [31:0]       rhs_ctrl,
    input  logic [LEAD_W-1:0] lead_cycles,
    input  logic [RUN_W-1:0]  run_cycles,
    output logic              busy,
    output logic              running,
    output logic              done,
    output logic              err,
    output logic [31:0]       m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [31:0]       m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WR_DLY  = 4'd1,
        S_WR_PKT  = 4'd2,
        S_WR_SEN  = 4'd3,
        S_RD_SEN  = 4'd4,
        S_LEAD    = 4'd5,
        S_WR_AEN  = 4'd6,
        S_RUN     = 4'd7,
        S_STOP_S  = 4'd8,
        S_RD_SDIS = 4'd9,
        S_STOP_A  = 4'd10
    } state_t;

    // Per-op sub-phase: launch the channels, wait for the response, and for
    // reads spend one cycle comparing the captured data.
    typedef enum logic [1:0] {
        PH_ISSUE = 2'd0,
        PH_WAIT  = 2'd1,
        PH_CHECK = 2'd2
    } phase_t;

    state_t            state_q,     state_d;
    phase_t            phase_q,     phase_d;
    logic              stop_pend_q, stop_pend_d;
    logic              err_q,       err_d;
    logic              done_q,      done_d;
    logic              awvalid_q,   awvalid_d;
    logic [31:0]       awaddr_q,    awaddr_d;
    logic              wvalid_q,    wvalid_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic              bready_q,    bready_d;
    logic              arvalid_q,   arvalid_d;
    logic [31:0]       araddr_q,    araddr_d;
    logic              rready_q,    rready_d;
    logic [31:0]       rdata_q,     rdata_d;
    logic [31:0]       delay_q,     delay_d;
    logic [31:0]       pktlen_q,    pktlen_d;
    logic [31:0]       rhd_ctrl_q,  rhd_ctrl_d;
    logic [31:0]       rhs_ctrl_q,  rhs_ctrl_d;
    logic [LEAD_W-1:0] lead_q,      lead_d;
    logic [RUN_W-1:0]  run_q,       run_d;
    logic [LEAD_W-1:0] lead_cnt_q,  lead_cnt_d;
    logic [RUN_W-1:0]  run_cnt_q,   run_cnt_d;

    logic        op_wr;
    logic        op_rd;
    logic [31:0] op_addr;
    logic [31:0] op_data;
    state_t      op_next;
    logic        op_fin;
    logic        setup;
    logic        wr_done;
    logic        rd_done;
    logic        lead_last;
    logic        run_last;

    assign wr_done   = m_axi_bvalid & bready_q;
    assign rd_done   = m_axi_rvalid & rready_q;
    assign setup     = state_q inside {S_WR_DLY, S_WR_PKT, S_WR_SEN, S_RD_SEN, S_WR_AEN};
    assign lead_last = (lead_q == '0) || (lead_cnt_q == lead_q - LEAD_W'(1));
    assign run_last  = (run_q != '0) && (run_cnt_q == run_q - RUN_W'(1));

    // Bus operation performed in each state and the state that follows it.
    always_comb begin
        op_wr   = 1'b0;
        op_rd   = 1'b0;
        op_addr = 32'h0;
        op_data = 32'h0;
        op_next = S_IDLE;
        case (state_q)
            S_WR_DLY:  begin op_wr = 1'b1; op_addr = RHD_BASE + 32'h4; op_data = delay_q;    op_next = S_WR_PKT;  end
            S_WR_PKT:  begin op_wr = 1'b1; op_addr = RHD_BASE + 32'h8; op_data = pktlen_q;   op_next = S_WR_SEN;  end
            S_WR_SEN:  begin op_wr = 1'b1; op_addr = RHS_BASE;         op_data = rhs_ctrl_q; op_next = S_RD_SEN;  end
            S_RD_SEN:  begin op_rd = 1'b1; op_addr = RHS_BASE;                               op_next = S_LEAD;    end
            S_WR_AEN:  begin op_wr = 1'b1; op_addr = RHD_BASE;         op_data = rhd_ctrl_q; op_next = S_RUN;     end
            S_STOP_S:  begin op_wr = 1'b1; op_addr = RHS_BASE;                               op_next = S_RD_SDIS; end
            S_RD_SDIS: begin op_rd = 1'b1; op_addr = RHS_BASE;                               op_next = S_STOP_A;  end
            S_STOP_A:  begin op_wr = 1'b1; op_addr = RHD_BASE;                               op_next = S_IDLE;    end
            default:   op_next = S_IDLE;
        endcase
    end

    // Session sequencing, channel handshakes and error tracking.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        stop_pend_d = stop_pend_q;
        err_d       = err_q;
        done_d      = 1'b0;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        rready_d    = rready_q;
        rdata_d     = rdata_q;
        delay_d     = delay_q;
        pktlen_d    = pktlen_q;
        rhd_ctrl_d  = rhd_ctrl_q;
        rhs_ctrl_d  = rhs_ctrl_q;
        lead_d      = lead_q;
        run_d       = run_q;
        lead_cnt_d  = lead_cnt_q;
        run_cnt_d   = run_cnt_q;
        op_fin      = 1'b0;

        // Each channel retires independently once its handshake is seen.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q  && m_axi_wready)  wvalid_d  = 1'b0;
        if (arvalid_q && m_axi_arready) arvalid_d = 1'b0;
        if (wr_done) bready_d = 1'b0;
        if (rd_done) rready_d = 1'b0;
        if (wr_done && (m_axi_bresp != 2'b00)) err_d = 1'b1;
        if (rd_done && (m_axi_rresp != 2'b00)) err_d = 1'b1;

        // A stop during a setup op is held until that op finishes.
        if (stop && setup) stop_pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    delay_d     = rhd_delay;
                    pktlen_d    = rhd_pktlen;
                    rhd_ctrl_d  = rhd_ctrl;
                    rhs_ctrl_d  = rhs_ctrl;
                    lead_d      = lead_cycles;
                    run_d       = run_cycles;
                    err_d       = 1'b0;
                    stop_pend_d = stop;
                    state_d     = S_WR_DLY;
                end
            end
            S_LEAD: begin
                lead_cnt_d = lead_cnt_q + LEAD_W'(1);
                if (stop)           state_d = S_STOP_S;
                else if (lead_last) state_d = S_WR_AEN;
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
                if (stop || run_last) state_d = S_STOP_S;
            end
            default: begin
                case (phase_q)
                    PH_ISSUE: begin
                        if (op_wr) begin
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                            bready_d  = 1'b1;
                            awaddr_d  = op_addr;
                            wdata_d   = op_data;
                        end else if (op_rd) begin
                            arvalid_d = 1'b1;
                            rready_d  = 1'b1;
                            araddr_d  = op_addr;
                        end
                        phase_d = PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (op_wr && wr_done) op_fin = 1'b1;
                        if (op_rd && rd_done) begin
                            rdata_d = m_axi_rdata;
                            phase_d = PH_CHECK;
                        end
                    end
                    PH_CHECK: begin
                        op_fin = 1'b1;
                        if ((state_q == S_RD_SEN) && (rdata_q != rhs_ctrl_q)) err_d = 1'b1;
                        if ((state_q == S_RD_SDIS) && (rdata_q != 32'h0))     err_d = 1'b1;
                    end
                    default: phase_d = PH_ISSUE;
                endcase
                if (op_fin) begin
                    state_d = op_next;
                    // Any failure or stop during setup diverts straight to
                    // the shutdown ops so both cores are left disabled.
                    if (setup && (err_d || stop_pend_d)) state_d = S_STOP_S;
                end
            end
        endcase

        // Common bookkeeping on every state change.
        if (state_d != state_q) begin
            lead_cnt_d = '0;
            run_cnt_d  = '0;
            phase_d    = PH_ISSUE;
            if (state_d == S_STOP_S) stop_pend_d = 1'b0;
            if (state_d == S_IDLE)   done_d      = 1'b1;
        end
    end

    // State and datapath registers; reset drops every valid immediately.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_ISSUE;
            stop_pend_q <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= 32'h0;
            wvalid_q    <= 1'b0;
            wdata_q     <= 32'h0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= 32'h0;
            rready_q    <= 1'b0;
            rdata_q     <= 32'h0;
            delay_q     <= 32'h0;
            pktlen_q    <= 32'h0;
            rhd_ctrl_q  <= 32'h0;
            rhs_ctrl_q  <= 32'h0;
            lead_q      <= '0;
            run_q       <= '0;
            lead_cnt_q  <= '0;
            run_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            stop_pend_q <= stop_pend_d;
            err_q       <= err_d;
            done_q      <= done_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            rready_q    <= rready_d;
            rdata_q     <= rdata_d;
            delay_q     <= delay_d;
            pktlen_q    <= pktlen_d;
            rhd_ctrl_q  <= rhd_ctrl_d;
            rhs_ctrl_q  <= rhs_ctrl_d;
            lead_q      <= lead_d;
            run_q       <= run_d;
            lead_cnt_q  <= lead_cnt_d;
            run_cnt_q   <= run_cnt_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign running       = (state_q == S_RUN);
    assign done          = done_q;
    assign err           = err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_rhx_session_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rhx_session_sequencer
// Description : Directed self-checking bench for rhx_session_sequencer with a
//               small AXI4-Lite slave that logs every completed transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rhx_session_sequencer;

    localparam logic [31:0] C_RHD = 32'h0000_0000;
    localparam logic [31:0] C_RHS = 32'h0001_0000;

    logic        aclk = 1'b0;
    logic        areset;
    logic        start, stop;
    logic [31:0] rhd_delay, rhd_pktlen, rhd_ctrl, rhs_ctrl;
    logic [23:0] lead_cycles;
    logic [31:0] run_cycles;
    logic        busy, running, done, err;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    always #5 aclk = ~aclk;

    rhx_session_sequencer dut (
        .aclk(aclk), .areset(areset), .start(start), .stop(stop),
        .rhd_delay(rhd_delay), .rhd_pktlen(rhd_pktlen), .rhd_ctrl(rhd_ctrl),
        .rhs_ctrl(rhs_ctrl), .lead_cycles(lead_cycles), .run_cycles(run_cycles),
        .busy(busy), .running(running), .done(done), .err(err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // ---------------- slave model ----------------
    int          aw_stall = 0;
    int          b_delay  = 0;
    logic        rd_force_en = 1'b0;
    logic [31:0] rd_force_val = 32'h0;

    int          cyc = 0;
    int          aw_wait, b_cnt, aw_cyc_l;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_l, w_data_l, rhs_reg;
    int          wr_n = 0, rd_n = 0, aw_hs = 0, w_hs = 0;
    logic [31:0] wl_addr [128];
    logic [31:0] wl_data [128];
    int          wl_awcyc[128];
    logic [31:0] rl_addr [128];
    logic [31:0] rl_data [128];
    int          rl_cyc  [128];

    assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_stall);
    assign m_axi_wready  = m_axi_wvalid;
    assign m_axi_arready = m_axi_arvalid;
    assign m_axi_bresp   = 2'b00;
    assign m_axi_rresp   = 2'b00;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_wait <= 0; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0; m_axi_rdata <= 32'h0;
        end else begin
            if (m_axi_awvalid && !m_axi_awready) aw_wait <= aw_wait + 1;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_got <= 1'b1; aw_addr_l <= m_axi_awaddr; aw_wait <= 0;
                aw_cyc_l <= cyc; aw_hs <= aw_hs + 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_got <= 1'b1; w_data_l <= m_axi_wdata; w_hs <= w_hs + 1;
            end
            if (aw_got && w_got && !m_axi_bvalid) begin
                if (b_cnt >= b_delay) m_axi_bvalid <= 1'b1;
                else                  b_cnt <= b_cnt + 1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                m_axi_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
                wl_addr[wr_n] <= aw_addr_l; wl_data[wr_n] <= w_data_l;
                wl_awcyc[wr_n] <= aw_cyc_l; wr_n <= wr_n + 1;
                if (aw_addr_l == C_RHS) rhs_reg <= w_data_l;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rdata  <= rd_force_en ? rd_force_val :
                                (m_axi_araddr == C_RHS) ? rhs_reg : 32'h0;
                rl_addr[rd_n] <= m_axi_araddr;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                m_axi_rvalid <= 1'b0;
                rl_data[rd_n] <= m_axi_rdata; rl_cyc[rd_n] <= cyc; rd_n <= rd_n + 1;
            end
        end
    end

    // Level monitors sampled mid-cycle.
    int run_hi = 0, done_n = 0, awv_n = 0, wv_n = 0;
    always @(negedge aclk) begin
        if (running)       run_hi = run_hi + 1;
        if (done)          done_n = done_n + 1;
        if (m_axi_awvalid) awv_n  = awv_n + 1;
        if (m_axi_wvalid)  wv_n   = wv_n + 1;
    end

    // ---------------- checking helpers ----------------
    int n_err = 0, n_checks = 0;
    int wb, rb, runb, doneb, awvb, wvb, awhb, whb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        wb = wr_n; rb = rd_n; runb = run_hi; doneb = done_n;
        awvb = awv_n; wvb = wv_n; awhb = aw_hs; whb = w_hs;
    endtask

    task automatic cfg(input logic [31:0] dly, input logic [31:0] pkt, input logic [31:0] rhs,
                       input logic [31:0] rhd, input logic [23:0] ld, input logic [31:0] rn);
        rhd_delay = dly; rhd_pktlen = pkt; rhs_ctrl = rhs; rhd_ctrl = rhd;
        lead_cycles = ld; run_cycles = rn;
    endtask

    task automatic kick(input logic with_stop);
        @(negedge aclk); start = 1'b1; stop = with_stop;
        @(negedge aclk); start = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_n == doneb && k < budget) begin
            @(posedge aclk);
            k++;
        end
        chk(tag, 32'(done_n - doneb), 32'd1);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_addr"}, wl_addr[wb + idx], a);
        chk({tag, "_data"}, wl_data[wb + idx], d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        areset = 1'b1; start = 1'b0; stop = 1'b0;
        cfg(32'h0, 32'h0, 32'h0, 32'h0, 24'd0, 32'd0);
        repeat (3) @(negedge aclk);
        chk("reset_ctl", 32'({busy, running, done, err, m_axi_awvalid, m_axi_wvalid,
                              m_axi_bready, m_axi_arvalid, m_axi_rready}), 32'h0);
        chk("reset_addr", m_axi_awaddr | m_axi_araddr | m_axi_wdata, 32'h0);
        areset = 1'b0;
        repeat (2) @(negedge aclk);

        // Nominal session.
        cfg(32'h2222_2222, 32'd2, 32'h29, 32'h15, 24'd100, 32'd1000);
        @(posedge aclk); snap();
        kick(1'b0);
        chk("s1_busy", 32'(busy), 32'd1);
        wait_done("s1_done", 3000);
        chk("s1_nwr", 32'(wr_n - wb), 32'd6);
        chk_wr("s1_w0", 0, C_RHD + 32'h4, 32'h2222_2222);
        chk_wr("s1_w1", 1, C_RHD + 32'h8, 32'd2);
        chk_wr("s1_w2", 2, C_RHS,         32'h29);
        chk_wr("s1_w3", 3, C_RHD,         32'h15);
        chk_wr("s1_w4", 4, C_RHS,         32'h0);
        chk_wr("s1_w5", 5, C_RHD,         32'h0);
        chk("s1_nrd", 32'(rd_n - rb), 32'd2);
        chk("s1_rd0", rl_data[rb], 32'h29);
        chk("s1_rd1", rl_data[rb + 1], 32'h0);
        // readback handshake -> check cycle -> 100 LEAD cycles -> issue -> handshake
        chk("s1_lead_gap", 32'(wl_awcyc[wb + 3] - rl_cyc[rb]), 32'd103);
        chk("s1_run_len", 32'(run_hi - runb), 32'd1000);
        chk("s1_err", 32'(err), 32'd0);
        chk("s1_wstrb", 32'(m_axi_wstrb), 32'hF);
        @(negedge aclk);
        chk("s1_idle", 32'({busy, done}), 32'h0);

        // Slow awready, immediate wready on every write.
        aw_stall = 5;
        cfg(32'h1, 32'h2, 32'h29, 32'h15, 24'd0, 32'd5);
        @(posedge aclk); snap();
        kick(1'b0);
        wait_done("s2_done", 1000);
        chk("s2_nwr", 32'(wr_n - wb), 32'd6);
        chk("s2_aw_hs", 32'(aw_hs - awhb), 32'd6);
        chk("s2_w_hs", 32'(w_hs - whb), 32'd6);
        chk("s2_awv_cycles", 32'(awv_n - awvb), 32'd36);
        chk("s2_wv_cycles", 32'(wv_n - wvb), 32'd6);
        aw_stall = 0;

        // Readback mismatch aborts before RHD enable.
        rd_force_en = 1'b1; rd_force_val = 32'h09;
        cfg(32'h1, 32'h2, 32'h29, 32'h15, 24'd10, 32'd50);
        @(posedge aclk); snap();
        kick(1'b0);
        wait_done("s3_done", 1000);
        rd_force_en = 1'b0;
        chk("s3_err", 32'(err), 32'd1);
        chk("s3_nwr", 32'(wr_n - wb), 32'd5);
        chk_wr("s3_w3", 3, C_RHS, 32'h0);
        chk_wr("s3_w4", 4, C_RHD, 32'h0);
        chk("s3_run_len", 32'(run_hi - runb), 32'd0);

        // Open-ended run ended by stop; start clears the sticky err.
        cfg(32'h3, 32'h4, 32'h29, 32'h15, 24'd4, 32'd0);
        @(posedge aclk); snap();
        kick(1'b0);
        chk("s4_err_clr", 32'(err), 32'd0);
        begin
            int k = 0;
            while (!running && k < 300) begin @(negedge aclk); k++; end
            chk("s4_run_seen", 32'(running), 32'd1);
        end
        repeat (299) @(negedge aclk);
        stop = 1'b1;
        @(negedge aclk); stop = 1'b0;
        chk("s4_run_fell", 32'(running), 32'd0);
        wait_done("s4_done", 500);
        chk("s4_run_len", 32'(run_hi - runb), 32'd300);
        chk("s4_nwr", 32'(wr_n - wb), 32'd6);
        chk("s4_err", 32'(err), 32'd0);
        run_cycles = 32'd20;
        @(posedge aclk); snap();
        kick(1'b0);
        wait_done("s4b_done", 500);
        chk("s4b_run_len", 32'(run_hi - runb), 32'd20);
        chk("s4b_nwr", 32'(wr_n - wb), 32'd6);

        // Stop while WR_PKT awaits its response.
        b_delay = 10;
        @(posedge aclk); snap();
        kick(1'b0);
        begin
            int k = 0;
            while (!(m_axi_awvalid && m_axi_awaddr == C_RHD + 32'h8) && k < 200) begin
                @(negedge aclk); k++;
            end
            chk("s5_pkt_seen", m_axi_awaddr, C_RHD + 32'h8);
        end
        stop = 1'b1;
        @(negedge aclk); stop = 1'b0;
        wait_done("s5_done", 500);
        b_delay = 0;
        chk("s5_nwr", 32'(wr_n - wb), 32'd4);
        chk_wr("s5_w1", 1, C_RHD + 32'h8, 32'h4);
        chk_wr("s5_w2", 2, C_RHS, 32'h0);
        chk_wr("s5_w3", 3, C_RHD, 32'h0);
        chk("s5_nrd", 32'(rd_n - rb), 32'd1);

        // start and stop together: only WR_DLY, then shutdown.
        @(posedge aclk); snap();
        kick(1'b1);
        wait_done("s6_done", 500);
        chk("s6_nwr", 32'(wr_n - wb), 32'd3);
        chk_wr("s6_w0", 0, C_RHD + 32'h4, 32'h3);
        chk_wr("s6_w1", 1, C_RHS, 32'h0);

        // Asynchronous reset while the RHS enable write is outstanding.
        aw_stall = 20;
        @(posedge aclk); snap();
        kick(1'b0);
        begin
            int k = 0;
            while (!(m_axi_awvalid && m_axi_awaddr == C_RHS) && k < 300) begin
                @(negedge aclk); k++;
            end
            chk("s7_sen_seen", m_axi_awaddr, C_RHS);
        end
        areset = 1'b1;
        #1;
        chk("s7_rst_ctl", 32'({busy, running, done, err, m_axi_awvalid, m_axi_wvalid,
                               m_axi_bready, m_axi_arvalid, m_axi_rready}), 32'h0);
        chk("s7_rst_addr", m_axi_awaddr | m_axi_wdata, 32'h0);
        @(negedge aclk); areset = 1'b0; aw_stall = 0;
        repeat (3) @(negedge aclk);
        chk("s7_idle", 32'({busy, m_axi_awvalid}), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
